// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int unsigned TAPS = 9;

    function automatic int unsigned ACC_W(input int unsigned data_w);
        return 2 * data_w + 4;
    endfunction

    // Clamp a sign-extended value into the signed range of an out_w-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/conv_window_3x3.sv
// Two line buffers plus a 3x3 shift-register window; everything moves only on shift_i.
module conv_window_3x3
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned COL_W  = 5
) (
    input  logic                         clk,
    input  logic                         shift_i,
    input  logic [COL_W-1:0]             col_i,
    input  logic [DATA_W-1:0]            pix_i,
    output logic [TAPS-1:0][DATA_W-1:0]  win_o
);

    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];

    // lb0 holds row-1, lb1 holds row-2 at the same column.
    always_ff @(posedge clk) begin
        if (shift_i) begin
            lb0_q[col_i] <= pix_i;
            lb1_q[col_i] <= lb0_q[col_i];
            for (int unsigned r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_q[col_i];
            win_q[1][2] <= lb0_q[col_i];
            win_q[2][2] <= pix_i;
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win_o[r*3+c] = win_q[r][c];
        end
    end

endmodule

// File: rtl/conv2d_stream_3x3.sv
// Streaming 3x3 convolution: frame FSM, raster counters, 3-stage MAC and post-processing.
module conv2d_stream_3x3
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IMG_W   = 32,
    parameter int unsigned IMG_H   = 32,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHIFT   = 0,
    parameter int unsigned RELU_EN = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     kernel_we,
    input  logic [TAPS*DATA_W-1:0]   kernel_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last
);

    localparam int unsigned ACC = ACC_W(DATA_W);
    localparam int unsigned PW  = 2 * DATA_W;
    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e                      state_q, state_d;
    logic [CW-1:0]               col_q, col_d;
    logic [RW-1:0]               row_q, row_d;
    logic                        done_q, done_d;
    logic [TAPS-1:0][DATA_W-1:0] kernel_q;
    logic [TAPS-1:0][DATA_W-1:0] win;

    logic                        v1_q, last1_q, v2_q, last2_q;
    logic signed [PW-1:0]        prod_q [TAPS];
    logic                        out_valid_q, out_last_q;
    logic [OUT_W-1:0]            out_data_q, out_data_d;

    logic advance, push, frame_end;
    logic signed [ACC-1:0] acc_c, shifted_c;

    assign advance   = !out_valid_q | out_ready;
    assign in_ready  = (state_q == S_RUN) & advance;
    assign push      = in_valid & in_ready;
    assign frame_end = push & (col_q == COL_LAST) & (row_q == ROW_LAST);

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (push) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (frame_end) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
            kernel_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
            if (state_q == S_IDLE && kernel_we) kernel_q <= kernel_data;
        end
    end

    conv_window_3x3 #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .COL_W  (CW)
    ) u_window (
        .clk     (clk),
        .shift_i (push),
        .col_i   (col_q),
        .pix_i   (in_data),
        .win_o   (win)
    );

    always_comb begin
        acc_c = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            acc_c = acc_c + ACC'(prod_q[i]);
        end
        shifted_c = acc_c >>> SHIFT;
        if (RELU_EN != 0 && shifted_c < 0) shifted_c = '0;
        out_data_d = OUT_W'(saturate(64'(shifted_c), OUT_W));
    end

    // Valid/last flags need reset; datapath registers only move with advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (advance) begin
            v1_q        <= push & (row_q >= RW'(2)) & (col_q >= CW'(2));
            last1_q     <= frame_end;
            v2_q        <= v1_q;
            last2_q     <= last1_q;
            out_valid_q <= v2_q;
            out_last_q  <= last2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                prod_q[i] <= $signed(win[i]) * $signed(kernel_q[i]);
            end
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_3x3.sv
// Randomised bench for conv2d_stream_3x3 against a direct window-sum reference model.
module tb_conv2d_stream_3x3;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kernel_we = 1'b0;
    logic [71:0] kernel_data = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b1;

    logic        busy, done, in_ready, out_valid, out_last;
    logic [15:0] out_data;
    logic        busy2, done2, in_ready2, out_valid2, out_last2;
    logic [11:0] out_data2;

    conv2d_stream_3x3 #(
        .DATA_W(8), .IMG_W(W), .IMG_H(H), .OUT_W(16), .SHIFT(0), .RELU_EN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .kernel_we(kernel_we), .kernel_data(kernel_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    conv2d_stream_3x3 #(
        .DATA_W(8), .IMG_W(W), .IMG_H(H), .OUT_W(12), .SHIFT(2), .RELU_EN(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2),
        .kernel_we(kernel_we), .kernel_data(kernel_data),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    int pix [N];
    int kmod [9];
    int kalt [9];
    int got1 [$];
    int got2 [$];
    bit gotl [$];
    int exp1 [$];
    int exp2 [$];
    int hs_cyc [N];
    int first_ov, last_hs, done_cyc, stab_viol, ready_viol, extra_hs, sync_viol, last2_viol;
    bit done_busy;

    function automatic logic [71:0] pack_k(input int k [9]);
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[i*8 +: 8] = 8'(k[i]);
        return p;
    endfunction

    function automatic longint clamp(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: explicit 3x3 sum over the unpadded frame, then floor shift, ReLU, clamp.
    function automatic void build_expected();
        exp1.delete();
        exp2.delete();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                longint acc = 0;
                longint s;
                for (int i = 0; i < 9; i++)
                    acc += longint'(kmod[i]) * longint'(pix[(r - 2 + i / 3) * W + (c - 2 + i % 3)]);
                exp1.push_back(int'(clamp(acc, 16)));
                s = acc >>> 2;
                if (s < 0) s = 0;
                exp2.push_back(int'(clamp(s, 12)));
            end
        end
    endfunction

    function automatic void rand_pixels();
        for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(255)) - 128;
    endfunction

    function automatic void rand_kernel(output int k [9]);
        for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(255)) - 128;
    endfunction

    task automatic load_kernel(input int k [9]);
        @(negedge clk);
        kernel_we   = 1'b1;
        kernel_data = pack_k(k);
        @(negedge clk);
        kernel_we   = 1'b0;
        kmod        = k;
    endtask

    // Drives one frame and records what the DUTs produce; comparisons live in the tests.
    task automatic run_frame(input int vprob, input int rprob, input int stall_at, input int kwe_at);
        int idx = 0;
        int stall_left = 0;
        bit stalled_once = 1'b0;
        bit prev_hold = 1'b0;
        logic [15:0] prev_data = '0;
        got1.delete(); got2.delete(); gotl.delete();
        first_ov = -1; last_hs = -1; done_cyc = -1; done_busy = 1'b1;
        stab_viol = 0; ready_viol = 0; extra_hs = 0; sync_viol = 0; last2_viol = 0;
        for (int n = 0; n < 2000 && done_cyc < 0; n++) begin
            @(negedge clk);
            start     = (n == 0) || (n == kwe_at);
            kernel_we = (n == kwe_at);
            if (n == kwe_at) kernel_data = pack_k(kalt);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (stall_at >= 0 && !stalled_once && got1.size() == stall_at) begin
                stalled_once = 1'b1;
                out_ready    = 1'b0;
                stall_left   = 4;
            end else begin
                out_ready = ($urandom_range(99) < rprob);
            end
            in_valid = (idx >= N) ? 1'b1 : ($urandom_range(99) < vprob);
            in_data  = (idx < N) ? 8'(pix[idx]) : 8'($urandom);
            #1;
            if (out_valid2 !== out_valid || in_ready2 !== in_ready || busy2 !== busy || done2 !== done)
                sync_viol++;
            if (out_valid && !out_ready && in_ready) ready_viol++;
            if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data)) stab_viol++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (in_valid && in_ready) begin
                if (idx < N) begin
                    hs_cyc[idx] = cyc;
                    idx++;
                end else begin
                    extra_hs++;
                end
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                got1.push_back(int'($signed(out_data)));
                got2.push_back(int'($signed(out_data2)));
                gotl.push_back(out_last);
                if (out_last2 !== out_last) last2_viol++;
                last_hs = cyc;
            end
            if (done) begin
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
        @(negedge clk);
        start = 1'b0; kernel_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_identity_latency();
        int k [9];
        for (int i = 0; i < 9; i++) k[i] = 0;
        k[4] = 1;
        for (int i = 0; i < N; i++) pix[i] = i;
        load_kernel(k);
        build_expected();
        run_frame(100, 100, -1, -1);
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL ident_timeout got=no_done exp=done"); end
        checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL ident_count got=%0d exp=%0d", got1.size(), NOUT); end
        for (int i = 0; i < got1.size() && i < NOUT; i++) begin
            checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL ident_data[%0d] got=%0d exp=%0d", i, got1[i], exp1[i]); end
            checks++; if (gotl[i] !== (i == NOUT - 1)) begin errors++; $display("FAIL ident_last[%0d] got=%b exp=%b", i, gotl[i], i == NOUT - 1); end
        end
        checks++; if (first_ov != hs_cyc[2*W+2] + 3) begin errors++; $display("FAIL latency got=%0d exp=%0d", first_ov - hs_cyc[2*W+2], 3); end
        checks++; if (done_cyc != last_hs + 1) begin errors++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc, last_hs + 1); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b exp=0", done_busy); end
        checks++; if (extra_hs != 0) begin errors++; $display("FAIL drain_accept got=%0d exp=0", extra_hs); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            int k [9];
            rand_kernel(k);
            rand_pixels();
            load_kernel(k);
            build_expected();
            run_frame(60, 70, -1, -1);
            checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", f, got1.size(), NOUT); end
            for (int i = 0; i < got1.size() && i < NOUT; i++) begin
                checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL rand_data[%0d.%0d] got=%0d exp=%0d", f, i, got1[i], exp1[i]); end
                checks++; if (got2[i] !== exp2[i]) begin errors++; $display("FAIL rand_post[%0d.%0d] got=%0d exp=%0d", f, i, got2[i], exp2[i]); end
                checks++; if (gotl[i] !== (i == NOUT - 1)) begin errors++; $display("FAIL rand_last[%0d.%0d] got=%b exp=%b", f, i, gotl[i], i == NOUT - 1); end
            end
            checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stable got=%0d exp=0", stab_viol); end
            checks++; if (sync_viol + last2_viol != 0) begin errors++; $display("FAIL rand_sync got=%0d exp=0", sync_viol + last2_viol); end
        end
    endtask

    task automatic test_saturation();
        int k [9];
        for (int i = 0; i < 9; i++) k[i] = 127;
        load_kernel(k);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) pix[i] = (p == 0) ? 127 : -128;
            build_expected();
            run_frame(100, 100, -1, -1);
            checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", p, got1.size(), NOUT); end
            for (int i = 0; i < got1.size() && i < NOUT; i++) begin
                checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL sat_data[%0d.%0d] got=%0d exp=%0d", p, i, got1[i], exp1[i]); end
                checks++; if (got2[i] !== exp2[i]) begin errors++; $display("FAIL sat_relu[%0d.%0d] got=%0d exp=%0d", p, i, got2[i], exp2[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int k [9];
        rand_kernel(k);
        rand_pixels();
        load_kernel(k);
        build_expected();
        run_frame(100, 100, 2, -1);
        checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got1.size(), NOUT); end
        for (int i = 0; i < got1.size() && i < NOUT; i++) begin
            checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got1[i], exp1[i]); end
        end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
        checks++; if (ready_viol != 0) begin errors++; $display("FAIL bp_in_ready got=%0d exp=0", ready_viol); end
    endtask

    task automatic test_kernel_we_busy();
        int k [9];
        rand_kernel(k);
        rand_kernel(kalt);
        rand_pixels();
        load_kernel(k);
        build_expected();
        run_frame(100, 100, -1, 8);
        checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL kbusy_count got=%0d exp=%0d", got1.size(), NOUT); end
        for (int i = 0; i < got1.size() && i < NOUT; i++) begin
            checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL kbusy_data[%0d] got=%0d exp=%0d", i, got1[i], exp1[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kbusy_idle got=%b exp=0", busy); end
        end
        rand_pixels();
        build_expected();
        run_frame(80, 80, -1, -1);
        checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL kbusy2_count got=%0d exp=%0d", got1.size(), NOUT); end
        for (int i = 0; i < got1.size() && i < NOUT; i++) begin
            checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL kbusy2_data[%0d] got=%0d exp=%0d", i, got1[i], exp1[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int k [9];
        rand_kernel(k);
        load_kernel(k);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_done got=%b exp=0", done); end
        end
        // The reset cleared the coefficient register, so every output must be zero.
        for (int i = 0; i < 9; i++) kmod[i] = 0;
        rand_pixels();
        build_expected();
        run_frame(90, 90, -1, -1);
        checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL mrst_zero_count got=%0d exp=%0d", got1.size(), NOUT); end
        for (int i = 0; i < got1.size() && i < NOUT; i++) begin
            checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL mrst_zero_data[%0d] got=%0d exp=%0d", i, got1[i], exp1[i]); end
        end
        rand_kernel(k);
        rand_pixels();
        load_kernel(k);
        build_expected();
        run_frame(90, 90, -1, -1);
        checks++; if (got1.size() != NOUT) begin errors++; $display("FAIL mrst_count got=%0d exp=%0d", got1.size(), NOUT); end
        for (int i = 0; i < got1.size() && i < NOUT; i++) begin
            checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL mrst_data[%0d] got=%0d exp=%0d", i, got1[i], exp1[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_identity_latency();
        test_random_frames();
        test_saturation();
        test_backpressure();
        test_kernel_we_busy();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
